mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 6 +
 rtl/mem_arb_pick.sv | 15 +
 rtl/mem_arb.sv | 100 ++++++++++
 tb/tb_mem_arb.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding and default widths for the two-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: picks the winning port (0 or 1) from two requests and the last-granted pointer.
// MEM_ARB_FIXED_PRIO_EN makes port 0 always win and ignores the pointer.
module mem_arb_pick (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_ptr,
  output logic o_winner
);
`ifdef MEM_ARB_FIXED_PRIO_EN
  // pointer only steers the don't-care no-request case
  assign o_winner = ~i_req0 & (i_req1 | i_ptr);
`else
  assign o_winner = (i_req0 & i_req1) ? ~i_ptr : i_req1;
`endif
endmodule

// File: rtl/mem_arb.sv
// mem_arb: two-port (CPU/loader) single-memory arbiter, IDLE->ACCESS(->RDWAIT) per transaction.
// Round-robin by default; MEM_ARB_FIXED_PRIO_EN gives port 0 fixed priority.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out
);
  state_t            r_state, w_next;
  logic              r_win, r_we, r_rv0, r_rv1;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rd0, r_rd1;
  logic              w_any, w_win, w_ptr, w_arb;

  assign w_any = req0 | req1;
  assign w_arb = (r_state == IDLE) & w_any;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_ptr = 1'b0;
`else
  logic r_last;
  // reset to 1 so the first contested arbitration favours port 0
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_last <= 1'b1;
    else if (w_arb) r_last <= w_win;
  assign w_ptr = r_last;
`endif

  mem_arb_pick u_pick (
    .i_req0  (req0),
    .i_req1  (req1),
    .i_ptr   (w_ptr),
    .o_winner(w_win)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE)   ? (w_any ? ACCESS : IDLE) :
             (r_state == ACCESS) ? (r_we ? IDLE : RDWAIT) : IDLE;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
      r_rd0   <= '0;
      r_rd1   <= '0;
    end else begin
      r_rv0 <= (r_state == RDWAIT) & ~r_win;
      r_rv1 <= (r_state == RDWAIT) & r_win;
      if (w_arb) begin
        r_win   <= w_win;
        r_we    <= w_win ? we1 : we0;
        r_addr  <= w_win ? addr1 : addr0;
        r_wdata <= w_win ? wdata1 : wdata0;
      end
      if (r_state == RDWAIT && !r_win) r_rd0 <= mem_data_out;
      if (r_state == RDWAIT && r_win) r_rd1 <= mem_data_out;
    end

  // address/data only change on arbitration, so they hold outside a transaction
  assign mem_address = r_addr;
  assign mem_data_in = r_wdata;
  assign mem_write   = (r_state == ACCESS) & r_we;
  assign gnt0        = (r_state == ACCESS) & ~r_win;
  assign gnt1        = (r_state == ACCESS) & r_win;
  assign rvalid0     = r_rv0;
  assign rvalid1     = r_rv1;
  assign rdata0      = r_rd0;
  assign rdata1      = r_rd1;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed self-checking bench for mem_arb with a behavioural 64K x 32 memory.
module tb_mem_arb;
  logic        clk = 1'b0, reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_write;
  logic [31:0] rdata0, rdata1, mem_data_in, mem_data_out;
  logic [15:0] mem_address;
  logic [31:0] mem [0:65535];
  int n_vec = 0, n_err = 0;

  mem_arb dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;
  assign mem_data_out = mem[mem_address];
  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_data_in;

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_write} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctl got %b want 00000", {gnt0, gnt1, rvalid0, rvalid1, mem_write});
    end
    n_vec++;
    if ({mem_address, mem_data_in, rdata0, rdata1} !== 112'h0) begin
      n_err++; $display("FAIL reset_data got %h want 0", {mem_address, mem_data_in, rdata0, rdata1});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1, mem_write} !== 3'b000) begin
      n_err++; $display("FAIL idle_no_req got %b want 000", {gnt0, gnt1, mem_write});
    end
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1, mem_write} !== 3'b101) begin
      n_err++; $display("FAIL wr_gnt got %b want 101", {gnt0, gnt1, mem_write});
    end
    n_vec++;
    if ({mem_address, mem_data_in} !== {16'h0010, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL wr_bus got %h/%h want 0010/deadbeef", mem_address, mem_data_in);
    end
    req0 = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({gnt0, mem_write} !== 2'b00) begin
      n_err++; $display("FAIL wr_one_cycle got %b want 00", {gnt0, mem_write});
    end
    req0 = 1'b1; we0 = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1, mem_write} !== 3'b100) begin
      n_err++; $display("FAIL rd_gnt got %b want 100", {gnt0, gnt1, mem_write});
    end
    req0 = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({gnt0, mem_write, rvalid0, mem_address} !== {3'b000, 16'h0010}) begin
      n_err++; $display("FAIL rdwait got %b/%h want 000/0010", {gnt0, mem_write, rvalid0}, mem_address);
    end
    @(negedge clk);
    n_vec++;
    if ({rvalid0, rvalid1, rdata0} !== {2'b10, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL rd_ret got %b/%h want 10/deadbeef", {rvalid0, rvalid1}, rdata0);
    end
    @(negedge clk);
    n_vec++;
    if ({rvalid0, rdata0} !== {1'b0, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL rd_hold got %b/%h want 0/deadbeef", rvalid0, rdata0);
    end
  endtask

  task automatic test_reset_mid_rdwait();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_write, mem_address, mem_data_in, rdata0, rdata1} !== 117'h0) begin
      n_err++; $display("FAIL abort_zero got %b %h %h %h %h want all 0",
        {gnt0, gnt1, rvalid0, rvalid1, mem_write}, mem_address, mem_data_in, rdata0, rdata1);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if ({gnt0, gnt1, rvalid0, rvalid1, mem_write} !== 5'b0) begin
        n_err++; $display("FAIL abort_quiet[%0d] got %b want 00000", i, {gnt0, gnt1, rvalid0, rvalid1, mem_write});
      end
    end
  endtask

  task automatic test_round_robin();
    logic        w;
    logic [31:0] exp_d;
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 16'h0100; addr1 = 16'h0200;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      w = 1'b0;
`else
      w = i[0];
`endif
      exp_d = w ? 32'hC0DE0200 : 32'hC0DE0100;
      @(negedge clk);
      n_vec++;
      if ({gnt0, gnt1} !== {~w, w}) begin
        n_err++; $display("FAIL rr_gnt[%0d] got %b want %b", i, {gnt0, gnt1}, {~w, w});
      end
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if ({rvalid0, rvalid1, (w ? rdata1 : rdata0)} !== {~w, w, exp_d}) begin
        n_err++; $display("FAIL rr_rv[%0d] got %b/%h want %b/%h", i, {rvalid0, rvalid1},
          (w ? rdata1 : rdata0), {~w, w}, exp_d);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] exp_r1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_r1 = 32'h0;
`else
    exp_r1 = 32'hC0DE0200;
`endif
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'hFFFF; wdata1 = 32'h00000001;
    @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1, mem_write, mem_address} !== {3'b011, 16'hFFFF}) begin
      n_err++; $display("FAIL wrap_wr got %b/%h want 011/ffff", {gnt0, gnt1, mem_write}, mem_address);
    end
    req1 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'hFFFF;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({rvalid0, rdata0} !== {1'b1, 32'h00000001}) begin
      n_err++; $display("FAIL wrap_rd got %b/%h want 1/00000001", rvalid0, rdata0);
    end
    n_vec++;
    if (rdata1 !== exp_r1) begin
      n_err++; $display("FAIL wrap_r1 got %h want %h", rdata1, exp_r1);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = {16'hC0DE, a[15:0]};
    test_reset();
    test_write_read();
    test_reset_mid_rdwait();
    test_round_robin();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
